// File: rtl/t03_sram_pkg.sv
// rtl/t03_sram_pkg.sv - shared widths, requester ids and FSM states for the dual-requester SRAM controller
package t03_sram_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/t03_sram_rr_arb.sv
// rtl/t03_sram_rr_arb.sv - two-way read-port arbiter; round-robin when T03_SRAM_RR_EN is defined, data-first otherwise
module t03_sram_rr_arb
    import t03_sram_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef T03_SRAM_RR_EN
    req_e ptr_q;
    logic contend;

    assign contend = req[REQ_I] & req[REQ_D];

    // pointer names the side that wins the next contended cycle
    always_comb begin
        gnt = req;
        if (contend) begin
            gnt        = '0;
            gnt[ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q <= REQ_I;
        end else if (contend) begin
            ptr_q <= (ptr_q == REQ_I) ? REQ_D : REQ_I;
        end
    end
`else
    logic unused_clk_rst;

    // clock and reset only feed the pointer in round-robin builds
    assign unused_clk_rst = clk ^ nrst;

    always_comb begin
        gnt = req;
        if (req[REQ_D]) begin
            gnt[REQ_I] = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/t03_sram_ctrl.sv
// rtl/t03_sram_ctrl.sv - instruction/data requesters onto a 1W/1R SRAM; read arbitration style set by T03_SRAM_RR_EN
module t03_sram_ctrl
    import t03_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    output logic                  busy
);

    state_e                i_state_q, i_state_d;
    state_e                d_state_q, d_state_d;
    logic                  ready_q;
    logic                  d_wr_q;
    logic                  i_elig, d_elig, wr_gnt, i_cand;
    logic                  i_gnt, d_rd_gnt, d_gnt;
    logic [1:0]            rd_req, rd_gnt;
    logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0] din0_q;

    // ready_q holds off grants until the first edge after reset release
    assign i_elig = ready_q & i_req & (i_state_q == IDLE) & ~i_ack;
    assign d_elig = ready_q & d_req & (d_state_q == IDLE) & ~d_ack;
    assign wr_gnt = d_elig & d_we;

    // a same-address write wins; the instruction read retries next cycle
    assign i_cand = i_elig & ~(wr_gnt & (i_addr == d_addr));

    assign rd_req[REQ_I] = i_cand;
    assign rd_req[REQ_D] = d_elig & ~d_we;

    t03_sram_rr_arb u_arb (
        .clk  (clk),
        .nrst (nrst),
        .req  (rd_req),
        .gnt  (rd_gnt)
    );

    assign i_gnt    = rd_gnt[REQ_I];
    assign d_rd_gnt = rd_gnt[REQ_D];
    assign d_gnt    = wr_gnt | d_rd_gnt;

    always_comb begin
        i_state_d = i_state_q;
        d_state_d = d_state_q;
        case (i_state_q)
            IDLE:    if (i_gnt) i_state_d = WAIT;
            WAIT:    i_state_d = IDLE;
            default: i_state_d = IDLE;
        endcase
        case (d_state_q)
            IDLE:    if (d_gnt) d_state_d = WAIT;
            WAIT:    d_state_d = IDLE;
            default: d_state_d = IDLE;
        endcase
    end

    always_comb begin
        sram_csb0  = ~wr_gnt;
        sram_addr0 = wr_gnt ? d_addr : addr0_q;
        sram_din0  = wr_gnt ? d_wdata : din0_q;
        sram_csb1  = ~(i_gnt | d_rd_gnt);
        sram_addr1 = i_gnt ? i_addr : (d_rd_gnt ? d_addr : addr1_q);
        // a requester counts as waiting from its grant cycle up to its ack cycle
        busy = i_gnt | d_gnt | (i_state_q == WAIT) | (d_state_q == WAIT);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ready_q   <= 1'b0;
            i_state_q <= IDLE;
            d_state_q <= IDLE;
            d_wr_q    <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            addr0_q   <= '0;
            din0_q    <= '0;
            addr1_q   <= '0;
        end else begin
            ready_q   <= 1'b1;
            i_state_q <= i_state_d;
            d_state_q <= d_state_d;
            if (d_gnt) begin
                d_wr_q <= d_we;
            end
            i_ack <= (i_state_q == WAIT);
            d_ack <= (d_state_q == WAIT);
            if (i_state_q == WAIT) begin
                i_rdata <= sram_dout1;
            end
            if ((d_state_q == WAIT) && !d_wr_q) begin
                d_rdata <= sram_dout1;
            end
            addr0_q <= sram_addr0;
            din0_q  <= sram_din0;
            addr1_q <= sram_addr1;
        end
    end

endmodule

// File: tb/tb_t03_sram_ctrl.sv
// tb/tb_t03_sram_ctrl.sv - directed and random checks of t03_sram_ctrl against a cycle-level model; honours T03_SRAM_RR_EN
module tb_t03_sram_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, sram_csb0, sram_csb1, busy;
    logic [DW-1:0] i_rdata, d_rdata, sram_din0, sram_dout1;
    logic [AW-1:0] sram_addr0, sram_addr1;

    always #5 clk = ~clk;

    t03_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1),
        .busy       (busy)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 32'h9E3779B1 * ({22'd0, a} + 32'd1);
    endfunction

    // synchronous SRAM: write on port 0, registered read on port 1
    logic [DW-1:0] sram [0:(1<<AW)-1];
    bit            sram_wr [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_csb0) begin
            sram[sram_addr0]    <= sram_din0;
            sram_wr[sram_addr0] <= 1'b1;
        end
        if (!sram_csb1) begin
            sram_dout1 <= sram_wr[sram_addr1] ? sram[sram_addr1] : init_word(sram_addr1);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // reference model state: grant cycle of each requester's latest transaction
    int            i_g = -100, d_g = -100;
    bit            d_g_rd;
    logic [DW-1:0] i_data, d_data, e_i_rdata, e_d_rdata, lastdin;
    logic [AW-1:0] last0, last1;
    bit            favor_d, armed;
    bit            e_i_ack, e_d_ack;
    logic [DW-1:0] ref_mem [int];

    logic          o_i_ack, o_d_ack, o_csb0, o_csb1, o_busy;
    logic [DW-1:0] o_i_rdata, o_d_rdata, o_din0;
    logic [AW-1:0] o_addr0, o_addr1;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    task automatic model_step();
        bit            ie, de, wg, ic, dr, ig, dg, b;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] w0;
        o_i_ack = i_ack; o_d_ack = d_ack; o_i_rdata = i_rdata; o_d_rdata = d_rdata;
        o_csb0 = sram_csb0; o_csb1 = sram_csb1; o_addr0 = sram_addr0; o_addr1 = sram_addr1;
        o_din0 = sram_din0; o_busy = busy;
        if (!nrst) begin
            i_g = -100; d_g = -100; e_i_rdata = '0; e_d_rdata = '0;
            last0 = '0; last1 = '0; lastdin = '0; armed = 1'b0;
            e_i_ack = 1'b0; e_d_ack = 1'b0;
`ifdef T03_SRAM_RR_EN
            favor_d = 1'b0;
`else
            favor_d = 1'b1;
`endif
            chk("rst_i_ack", o_i_ack, 0);  chk("rst_d_ack", o_d_ack, 0);
            chk("rst_i_rdata", o_i_rdata, 0); chk("rst_d_rdata", o_d_rdata, 0);
            chk("rst_csb0", o_csb0, 1);    chk("rst_csb1", o_csb1, 1);
            chk("rst_addr0", o_addr0, 0);  chk("rst_din0", o_din0, 0);
            chk("rst_addr1", o_addr1, 0);  chk("rst_busy", o_busy, 0);
            return;
        end
        e_i_ack = (cyc == i_g + 2);
        e_d_ack = (cyc == d_g + 2);
        if (e_i_ack) e_i_rdata = i_data;
        if (e_d_ack && d_g_rd) e_d_rdata = d_data;
        ie = armed && i_req && (cyc >= i_g + 3);
        de = armed && d_req && (cyc >= d_g + 3);
        wg = de && d_we;
        ic = ie && !(wg && i_addr == d_addr);
        dr = de && !d_we;
        if (ic && dr) begin
            ig = !favor_d;
            dg = favor_d;
`ifdef T03_SRAM_RR_EN
            favor_d = !favor_d;
`endif
        end else begin
            ig = ic;
            dg = dr;
        end
        a0 = wg ? d_addr : last0;
        w0 = wg ? d_wdata : lastdin;
        a1 = ig ? i_addr : (dg ? d_addr : last1);
        b  = ig || wg || dg || (cyc == i_g + 1) || (cyc == d_g + 1);
        chk("i_ack", o_i_ack, e_i_ack);     chk("d_ack", o_d_ack, e_d_ack);
        chk("i_rdata", o_i_rdata, e_i_rdata); chk("d_rdata", o_d_rdata, e_d_rdata);
        chk("csb0", o_csb0, !wg);           chk("csb1", o_csb1, !(ig || dg));
        chk("addr0", o_addr0, a0);          chk("din0", o_din0, w0);
        chk("addr1", o_addr1, a1);          chk("busy", o_busy, b);
        if (ig) begin i_g = cyc; i_data = ref_rd(i_addr); end
        if (dg) begin d_g = cyc; d_g_rd = 1'b1; d_data = ref_rd(d_addr); end
        if (wg) begin d_g = cyc; d_g_rd = 1'b0; ref_mem[int'(d_addr)] = d_wdata; end
        last0 = a0; lastdin = w0; last1 = a1;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        armed = nrst;
        cyc++;
        #1;
    endtask

    task automatic d_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output int g_at, output int a_at);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        g_at = -1; a_at = -1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (g_at < 0 && (we ? !o_csb0 : !o_csb1)) g_at = k;
            if (o_d_ack) begin
                a_at = k;
                break;
            end
        end
        d_req = 1'b0; d_we = 1'b0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = AW'($urandom);
        return ($urandom_range(0, 3) == 0) ? a : AW'(10'h040 + AW'($urandom_range(0, 3)));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  g, a, gi, gd, gw, ia;
        bit  i_on, d_on;
        nrst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) cycle();
        chk("lit_rst_csb1", o_csb1, 1);
        chk("lit_rst_busy", o_busy, 0);
        nrst = 1'b1;
        cycle();

        // contended reads, four rounds
        for (int r = 0; r < 4; r++) begin
            i_req = 1'b1; i_addr = 10'h020; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h030;
            i_on = 1'b1; d_on = 1'b1; gi = -1; gd = -1;
            for (int k = 0; k < 8 && (i_on || d_on); k++) begin
                cycle();
                if (!o_csb1 && o_addr1 == 10'h020) gi = k;
                if (!o_csb1 && o_addr1 == 10'h030) gd = k;
                if (o_i_ack) begin i_on = 1'b0; i_req = 1'b0; end
                if (o_d_ack) begin d_on = 1'b0; d_req = 1'b0; end
            end
            i_req = 1'b0; d_req = 1'b0;
            chk("arb_done", {30'd0, i_on, d_on}, 0);
`ifdef T03_SRAM_RR_EN
            chk("arb_i_slot", gi, (r % 2 == 0) ? 0 : 1);
            chk("arb_d_slot", gd, (r % 2 == 0) ? 1 : 0);
`else
            chk("arb_i_slot", gi, 1);
            chk("arb_d_slot", gd, 0);
`endif
        end

        // instruction read of a preloaded word
        d_xfer(1'b1, 10'h010, 32'hDEADBEEF, g, a);
        chk("wr10_grant", g, 0); chk("wr10_ack", a, 2);
        i_req = 1'b1; i_addr = 10'h010;
        cycle(); chk("r31_csb1_n", o_csb1, 0); chk("r31_busy_n", o_busy, 1);
        cycle(); chk("r31_busy_n1", o_busy, 1); chk("r31_ack_n1", o_i_ack, 0);
        cycle(); chk("r31_ack_n2", o_i_ack, 1); chk("r31_rdata", o_i_rdata, 32'hDEADBEEF);
        chk("r31_busy_n2", o_busy, 0);
        i_req = 1'b0;

        // top address write then read back
        d_xfer(1'b1, 10'h3FF, 32'h12345678, g, a);
        chk("r32_wr_grant", g, 0); chk("r32_wr_ack", a, 2);
        d_xfer(1'b0, 10'h3FF, 32'h0, g, a);
        chk("r32_rd_ack", a, 2); chk("r32_rdata", o_d_rdata, 32'h12345678);

        // same-address write and instruction read
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h040; d_wdata = 32'hA5A5A5A5;
        i_req = 1'b1; i_addr = 10'h040;
        gw = -1; gi = -1; ia = -1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (gw < 0 && !o_csb0) gw = k;
            if (gi < 0 && !o_csb1) gi = k;
            if (o_d_ack) begin d_req = 1'b0; d_we = 1'b0; end
            if (o_i_ack) begin ia = k; break; end
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk("r34_wr_slot", gw, 0); chk("r34_rd_slot", gi, 1); chk("r34_ack_slot", ia, 3);
        chk("r34_rdata", o_i_rdata, 32'hA5A5A5A5);

        // reset in the middle of a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
        cycle(); chk("r35_grant", o_csb1, 0);
        nrst = 1'b0;
        cycle();
        chk("r35_d_ack", o_d_ack, 0); chk("r35_d_rdata", o_d_rdata, 0);
        chk("r35_csb0", o_csb0, 1); chk("r35_csb1", o_csb1, 1); chk("r35_busy", o_busy, 0);
        nrst = 1'b1; d_req = 1'b0;
        cycle(); chk("r35_no_ack", o_d_ack, 0); chk("r35_rdata_clr", o_d_rdata, 0);
        d_xfer(1'b0, 10'h3FF, 32'h0, g, a);
        chk("r35_new_grant", g, 0); chk("r35_new_ack", a, 2);
        chk("r35_new_rdata", o_d_rdata, 32'h12345678);

        // random traffic with a mid-run reset pulse
        i_on = 1'b0; d_on = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) nrst = 1'b0;
            if (n == 1502) nrst = 1'b1;
            if (!i_on) begin
                if ($urandom_range(0, 2) != 0) begin
                    i_on = 1'b1; i_req = 1'b1; i_addr = rnd_addr();
                end else begin
                    i_req = 1'b0; i_addr = AW'($urandom);
                end
            end
            if (!d_on) begin
                d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
                if ($urandom_range(0, 2) != 0) begin
                    d_on = 1'b1; d_req = 1'b1;
                end else begin
                    d_req = 1'b0;
                end
            end
            cycle();
            if (e_i_ack) i_on = 1'b0;
            if (e_d_ack) d_on = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
